// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the single MAC TX Avalon-ST stream.
// Grant is locked from SOP to EOP; output beat is registered; per-port packet and drop counters.
module eth_tx_arbiter #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned EMPTY_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             in_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS-1:0]             in_sop,
  input  logic [NUM_PORTS-1:0]             in_eop,
  input  logic [NUM_PORTS-1:0]             in_error,
  input  logic [NUM_PORTS*EMPTY_WIDTH-1:0] in_empty,
  output logic [NUM_PORTS-1:0]             in_ready,
  input  logic                             tx_ready_in,
  output logic                             tx_valid_out,
  output logic                             tx_sop_out,
  output logic                             tx_eop_out,
  output logic                             tx_error_out,
  output logic [DATA_WIDTH-1:0]            tx_data_out,
  output logic [EMPTY_WIDTH-1:0]           tx_empty_out,
  output logic [NUM_PORTS*32-1:0]          pkt_cnt_out,
  output logic [15:0]                      drop_cnt_out
);

  localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW = $clog2(NUM_PORTS + 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                  state;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           last_grant;

  logic [NUM_PORTS-1:0]    cand;
  logic [NUM_PORTS-1:0]    stray;
  logic                    found;
  logic [GW-1:0]           pick;
  logic [CW-1:0]           stray_n;
  logic [16:0]             drop_sum;
  logic [15:0]             drop_sat;
  logic                    sel_valid;
  logic                    sel_sop;
  logic                    sel_eop;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [EMPTY_WIDTH-1:0]  sel_empty;
  logic                    out_free;
  logic                    accept;

  assign cand     = in_valid & in_sop;
  assign stray    = in_valid & ~in_sop;
  assign out_free = !tx_valid_out || tx_ready_in;
  assign accept   = (state == LOCKED) && sel_valid && out_free;
  assign drop_sum = {1'b0, drop_cnt_out} + 17'(stray_n);
  assign drop_sat = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  // Round-robin search starting one past the last granted port.
  always_comb begin : rr_search
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (!found && cand[p] && (p == (32'(last_grant) + k) % NUM_PORTS)) begin
          found = 1'b1;
          pick  = GW'(p);
        end
      end
    end
  end

  always_comb begin : stray_count
    stray_n = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      stray_n = stray_n + CW'(stray[p]);
    end
  end

  always_comb begin : beat_mux
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_err   = 1'b0;
    sel_data  = '0;
    sel_empty = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (GW'(p) == grant) begin
        sel_valid = in_valid[p];
        sel_sop   = in_sop[p];
        sel_eop   = in_eop[p];
        sel_err   = in_error[p];
        sel_data  = in_data[p*DATA_WIDTH +: DATA_WIDTH];
        sel_empty = in_empty[p*EMPTY_WIDTH +: EMPTY_WIDTH];
      end
    end
  end

  // Stray beats are sunk in IDLE; only the granted port is served while LOCKED.
  always_comb begin : ready_gen
    in_ready = '0;
    if (!reset) begin
      if (state == IDLE) begin
        in_ready = stray;
      end else begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (GW'(p) == grant) in_ready[p] = out_free;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin : arb_seq
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= GW'(NUM_PORTS - 1);
      tx_valid_out <= 1'b0;
      tx_sop_out   <= 1'b0;
      tx_eop_out   <= 1'b0;
      tx_error_out <= 1'b0;
      tx_data_out  <= '0;
      tx_empty_out <= '0;
      pkt_cnt_out  <= '0;
      drop_cnt_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          drop_cnt_out <= drop_sat;
          if (found) begin
            grant <= pick;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && sel_eop) begin
            state      <= IDLE;
            last_grant <= grant;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
              if (GW'(p) == grant) pkt_cnt_out[p*32 +: 32] <= pkt_cnt_out[p*32 +: 32] + 32'd1;
            end
          end
        end
      endcase

      if (accept) begin
        tx_valid_out <= 1'b1;
        tx_sop_out   <= sel_sop;
        tx_eop_out   <= sel_eop;
        tx_error_out <= sel_err;
        tx_data_out  <= sel_data;
        tx_empty_out <= sel_empty;
      end else if (tx_ready_in) begin
        tx_valid_out <= 1'b0;
      end
    end
  end

endmodule
